// File: rtl/axis_width_conv.sv
// AXI-Stream word-width converter: upsizes, downsizes or register-slices by an integer ratio.
// Define AXIS_WC_ASSERT_EN to compile in the protocol checkers.
module axis_width_conv #(
    parameter int WORD_W   = 8,
    parameter int RX_WORDS = 1,
    parameter int TX_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    input  logic [RX_WORDS*WORD_W-1:0]   rx_data,
    input  logic [RX_WORDS-1:0]          rx_keep,
    input  logic                         rx_last,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [TX_WORDS*WORD_W-1:0]   tx_data,
    output logic [TX_WORDS-1:0]          tx_keep,
    output logic                         tx_last
);
    localparam int RXW = RX_WORDS * WORD_W;
    localparam int TXW = TX_WORDS * WORD_W;

    logic           tx_valid_q, tx_valid_d;
    logic [TXW-1:0] tx_data_q, tx_data_d;
    logic [TX_WORDS-1:0] tx_keep_q, tx_keep_d;
    logic           tx_last_q, tx_last_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_keep_q  <= '0;
            tx_last_q  <= 1'b0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_keep_q  <= tx_keep_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_keep  = tx_keep_q;
    assign tx_last  = tx_last_q;

    if ((RX_WORDS % TX_WORDS != 0) && (TX_WORDS % RX_WORDS != 0)) begin : g_bad_ratio
        $error("axis_width_conv: RX_WORDS and TX_WORDS must divide one another");
    end

    if (RX_WORDS == TX_WORDS) begin : g_equal
        assign rx_ready = rstn & (!tx_valid_q | tx_ready);

        always_comb begin
            tx_valid_d = tx_valid_q;
            tx_data_d  = tx_data_q;
            tx_keep_d  = tx_keep_q;
            tx_last_d  = tx_last_q;
            if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
            if (rx_valid && rx_ready) begin
                tx_valid_d = 1'b1;
                tx_data_d  = rx_data;
                tx_keep_d  = rx_keep;
                tx_last_d  = rx_last;
            end
        end
    end else if (TX_WORDS > RX_WORDS) begin : g_up
        localparam int R  = TX_WORDS / RX_WORDS;
        localparam int CW = (R > 1) ? $clog2(R) : 1;
        logic [CW-1:0] cnt_q, cnt_d;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign rx_ready = rstn & (!tx_valid_q | tx_ready);

        // The tx register doubles as the accumulator; it is cleared when a beat leaves.
        always_comb begin
            tx_valid_d = tx_valid_q;
            tx_data_d  = tx_data_q;
            tx_keep_d  = tx_keep_q;
            tx_last_d  = tx_last_q;
            cnt_d      = cnt_q;
            if (tx_valid_q && tx_ready) begin
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
                tx_keep_d  = '0;
                tx_last_d  = 1'b0;
            end
            if (rx_valid && rx_ready) begin
                tx_data_d[int'(cnt_q)*RXW +: RXW]           = rx_data;
                tx_keep_d[int'(cnt_q)*RX_WORDS +: RX_WORDS] = rx_keep;
                if (cnt_q == CW'(R-1) || rx_last) begin
                    tx_valid_d = 1'b1;
                    tx_last_d  = rx_last;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end else begin : g_down
        localparam int R  = RX_WORDS / TX_WORDS;
        localparam int SW = (R > 1) ? $clog2(R) : 1;
        logic [RXW-1:0]      hold_data_q, hold_data_d;
        logic [RX_WORDS-1:0] hold_keep_q, hold_keep_d;
        logic                hold_last_q, hold_last_d;
        logic [SW-1:0]       sel_q, sel_d;
        int                  nxt, nxt_after, rx_first, rx_after;
        logic                fin;

        // Index of the first slice at or after start with any kept word; R means none.
        function automatic int first_slice(input logic [RX_WORDS-1:0] k, input int start);
            int r;
            r = R;
            for (int j = R - 1; j >= 0; j--)
                if (j >= start && |k[j*TX_WORDS +: TX_WORDS]) r = j;
            return r;
        endfunction

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                hold_data_q <= '0;
                hold_keep_q <= '0;
                hold_last_q <= 1'b0;
                sel_q       <= '0;
            end else begin
                hold_data_q <= hold_data_d;
                hold_keep_q <= hold_keep_d;
                hold_last_q <= hold_last_d;
                sel_q       <= sel_d;
            end
        end

        always_comb begin
            nxt       = first_slice(hold_keep_q, int'(sel_q) + 1);
            nxt_after = first_slice(hold_keep_q, nxt + 1);
            rx_first  = first_slice(rx_keep, 0);
            rx_after  = first_slice(rx_keep, rx_first + 1);
            fin       = (nxt == R);
        end

        assign rx_ready = rstn & (!tx_valid_q | (tx_ready & fin));

        always_comb begin
            tx_valid_d  = tx_valid_q;
            tx_data_d   = tx_data_q;
            tx_keep_d   = tx_keep_q;
            tx_last_d   = tx_last_q;
            hold_data_d = hold_data_q;
            hold_keep_d = hold_keep_q;
            hold_last_d = hold_last_q;
            sel_d       = sel_q;
            if (tx_valid_q && tx_ready) begin
                if (!fin) begin
                    tx_data_d = hold_data_q[nxt*TXW +: TXW];
                    tx_keep_d = hold_keep_q[nxt*TX_WORDS +: TX_WORDS];
                    tx_last_d = hold_last_q && (nxt_after == R);
                    sel_d     = SW'(nxt);
                end else begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                    tx_keep_d  = '0;
                    tx_last_d  = 1'b0;
                end
            end
            // Empty beats only survive when they carry the packet end.
            if (rx_valid && rx_ready) begin
                if (rx_first != R) begin
                    tx_valid_d  = 1'b1;
                    tx_data_d   = rx_data[rx_first*TXW +: TXW];
                    tx_keep_d   = rx_keep[rx_first*TX_WORDS +: TX_WORDS];
                    tx_last_d   = rx_last && (rx_after == R);
                    sel_d       = SW'(rx_first);
                    hold_data_d = rx_data;
                    hold_keep_d = rx_keep;
                    hold_last_d = rx_last;
                end else if (rx_last) begin
                    tx_valid_d  = 1'b1;
                    tx_data_d   = '0;
                    tx_keep_d   = '0;
                    tx_last_d   = 1'b1;
                    hold_keep_d = '0;
                    hold_last_d = 1'b1;
                    sel_d       = '0;
                end
            end
        end
    end

`ifdef AXIS_WC_ASSERT_EN
    a_rx_hold: assert property (@(posedge clk) disable iff (!rstn)
        rx_valid && !rx_ready |=> rx_valid && $stable(rx_data) && $stable(rx_keep) && $stable(rx_last))
        else $error("axis_width_conv: rx beat changed or withdrawn before handshake");

    a_rx_keep_contig: assert property (@(posedge clk) disable iff (!rstn)
        rx_valid |-> ((rx_keep + 1'b1) & rx_keep) == '0)
        else $error("axis_width_conv: rx_keep not low-aligned contiguous");

    a_tx_hold: assert property (@(posedge clk) disable iff (!rstn)
        tx_valid && !tx_ready |=> tx_valid)
        else $error("axis_width_conv: tx_valid dropped without tx_ready");

    if (TX_WORDS > RX_WORDS) begin : g_up_chk
        a_rx_keep_full: assert property (@(posedge clk) disable iff (!rstn)
            rx_valid && !rx_last |-> &rx_keep)
            else $error("axis_width_conv: partial rx_keep on non-last beat");
    end
`endif
endmodule

// File: tb/tb_axis_width_conv.sv
// Directed and randomized-backpressure bench for axis_width_conv in 1->4, 4->1 and 2->2 builds.
module tb_axis_width_conv;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int NP = 100;

    logic [8:0] up_q[$];
    logic [8:0] dn_q[$];

    // 1 -> 4 upsizer
    logic        up_rx_valid, up_rx_ready, up_rx_last, up_tx_valid, up_tx_ready, up_tx_last;
    logic [7:0]  up_rx_data;
    logic [0:0]  up_rx_keep;
    logic [31:0] up_tx_data;
    logic [3:0]  up_tx_keep;
    // 4 -> 1 downsizer
    logic        dn_rx_valid, dn_rx_ready, dn_rx_last, dn_tx_valid, dn_tx_ready, dn_tx_last;
    logic [31:0] dn_rx_data;
    logic [3:0]  dn_rx_keep;
    logic [7:0]  dn_tx_data;
    logic [0:0]  dn_tx_keep;
    // 2 -> 2 slice
    logic        eq_rx_valid, eq_rx_ready, eq_rx_last, eq_tx_valid, eq_tx_ready, eq_tx_last;
    logic [15:0] eq_rx_data, eq_tx_data;
    logic [1:0]  eq_rx_keep, eq_tx_keep;

    axis_width_conv #(.WORD_W(8), .RX_WORDS(1), .TX_WORDS(4)) u_up (
        .clk(clk), .rstn(rstn),
        .rx_valid(up_rx_valid), .rx_ready(up_rx_ready), .rx_data(up_rx_data),
        .rx_keep(up_rx_keep), .rx_last(up_rx_last),
        .tx_valid(up_tx_valid), .tx_ready(up_tx_ready), .tx_data(up_tx_data),
        .tx_keep(up_tx_keep), .tx_last(up_tx_last));

    axis_width_conv #(.WORD_W(8), .RX_WORDS(4), .TX_WORDS(1)) u_dn (
        .clk(clk), .rstn(rstn),
        .rx_valid(dn_rx_valid), .rx_ready(dn_rx_ready), .rx_data(dn_rx_data),
        .rx_keep(dn_rx_keep), .rx_last(dn_rx_last),
        .tx_valid(dn_tx_valid), .tx_ready(dn_tx_ready), .tx_data(dn_tx_data),
        .tx_keep(dn_tx_keep), .tx_last(dn_tx_last));

    axis_width_conv #(.WORD_W(8), .RX_WORDS(2), .TX_WORDS(2)) u_eq (
        .clk(clk), .rstn(rstn),
        .rx_valid(eq_rx_valid), .rx_ready(eq_rx_ready), .rx_data(eq_rx_data),
        .rx_keep(eq_rx_keep), .rx_last(eq_rx_last),
        .tx_valid(eq_tx_valid), .tx_ready(eq_tx_ready), .tx_data(eq_tx_data),
        .tx_keep(eq_tx_keep), .tx_last(eq_tx_last));

    // Present one upsizer beat at a negedge; returns at the negedge after it is taken.
    task automatic up_send(input logic [7:0] d, input logic l);
        up_rx_valid = 1'b1;
        up_rx_data  = d;
        up_rx_last  = l;
        up_rx_keep  = 1'b1;
        #4;
        total++;
        if (up_rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL up_send_rx_ready data=%02h got=%b want=1", d, up_rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total += 8;
        if (up_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_up_tx_valid got=%b want=0", up_tx_valid); end
        if (up_tx_data !== 32'h0) begin bad++; $display("FAIL reset_up_tx_data got=%h want=0", up_tx_data); end
        if (up_tx_keep !== 4'h0) begin bad++; $display("FAIL reset_up_tx_keep got=%b want=0", up_tx_keep); end
        if (up_tx_last !== 1'b0) begin bad++; $display("FAIL reset_up_tx_last got=%b want=0", up_tx_last); end
        if (up_rx_ready !== 1'b0) begin bad++; $display("FAIL reset_up_rx_ready got=%b want=0", up_rx_ready); end
        if (dn_rx_ready !== 1'b0) begin bad++; $display("FAIL reset_dn_rx_ready got=%b want=0", dn_rx_ready); end
        if (dn_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_dn_tx_valid got=%b want=0", dn_tx_valid); end
        if (eq_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_eq_tx_valid got=%b want=0", eq_tx_valid); end
        rstn = 1'b1;
        #1;
        total += 3;
        if (up_rx_ready !== 1'b1) begin bad++; $display("FAIL release_up_rx_ready got=%b want=1", up_rx_ready); end
        if (dn_rx_ready !== 1'b1) begin bad++; $display("FAIL release_dn_rx_ready got=%b want=1", dn_rx_ready); end
        if (eq_rx_ready !== 1'b1) begin bad++; $display("FAIL release_eq_rx_ready got=%b want=1", eq_rx_ready); end
        @(negedge clk);
    endtask

    task automatic test_upsize_full();
        up_tx_ready = 1'b1;
        up_send(8'h11, 1'b0);
        up_send(8'h22, 1'b0);
        up_send(8'h33, 1'b0);
        total++;
        if (up_tx_valid !== 1'b0) begin bad++; $display("FAIL upfull_early_valid got=%b want=0", up_tx_valid); end
        up_send(8'h44, 1'b1);
        up_rx_valid = 1'b0;
        total += 4;
        if (up_tx_valid !== 1'b1) begin bad++; $display("FAIL upfull_valid got=%b want=1", up_tx_valid); end
        if (up_tx_data !== 32'h44332211) begin bad++; $display("FAIL upfull_data got=%h want=44332211", up_tx_data); end
        if (up_tx_keep !== 4'b1111) begin bad++; $display("FAIL upfull_keep got=%b want=1111", up_tx_keep); end
        if (up_tx_last !== 1'b1) begin bad++; $display("FAIL upfull_last got=%b want=1", up_tx_last); end
        @(negedge clk);
        total++;
        if (up_tx_valid !== 1'b0) begin bad++; $display("FAIL upfull_drained got=%b want=0", up_tx_valid); end
    endtask

    task automatic test_upsize_short();
        up_tx_ready = 1'b1;
        up_send(8'hA1, 1'b0);
        up_send(8'hB2, 1'b1);
        up_rx_valid = 1'b0;
        total += 4;
        if (up_tx_valid !== 1'b1) begin bad++; $display("FAIL upshort_valid got=%b want=1", up_tx_valid); end
        if (up_tx_data !== 32'h0000B2A1) begin bad++; $display("FAIL upshort_data got=%h want=0000b2a1", up_tx_data); end
        if (up_tx_keep !== 4'b0011) begin bad++; $display("FAIL upshort_keep got=%b want=0011", up_tx_keep); end
        if (up_tx_last !== 1'b1) begin bad++; $display("FAIL upshort_last got=%b want=1", up_tx_last); end
        @(negedge clk);
        up_send(8'h5A, 1'b1);
        up_rx_valid = 1'b0;
        total += 2;
        if (up_tx_data !== 32'h0000005A) begin bad++; $display("FAIL upshort_slot0_data got=%h want=0000005a", up_tx_data); end
        if (up_tx_keep !== 4'b0001) begin bad++; $display("FAIL upshort_slot0_keep got=%b want=0001", up_tx_keep); end
        @(negedge clk);
    endtask

    task automatic test_downsize();
        dn_tx_ready = 1'b1;
        dn_rx_valid = 1'b1;
        dn_rx_data  = 32'hDDCCBBAA;
        dn_rx_keep  = 4'b0111;
        dn_rx_last  = 1'b1;
        #4;
        total++;
        if (dn_rx_ready !== 1'b1) begin bad++; $display("FAIL dn_rx_ready_idle got=%b want=1", dn_rx_ready); end
        @(negedge clk);
        dn_rx_valid = 1'b0;
        total += 4;
        if (dn_tx_valid !== 1'b1 || dn_tx_data !== 8'hAA) begin bad++; $display("FAIL dn_slice0 got=%b/%h want=1/aa", dn_tx_valid, dn_tx_data); end
        if (dn_tx_last !== 1'b0) begin bad++; $display("FAIL dn_slice0_last got=%b want=0", dn_tx_last); end
        if (dn_tx_keep !== 1'b1) begin bad++; $display("FAIL dn_slice0_keep got=%b want=1", dn_tx_keep); end
        if (dn_rx_ready !== 1'b0) begin bad++; $display("FAIL dn_busy_rx_ready got=%b want=0", dn_rx_ready); end
        @(negedge clk);
        total += 2;
        if (dn_tx_valid !== 1'b1 || dn_tx_data !== 8'hBB) begin bad++; $display("FAIL dn_slice1 got=%b/%h want=1/bb", dn_tx_valid, dn_tx_data); end
        if (dn_tx_last !== 1'b0) begin bad++; $display("FAIL dn_slice1_last got=%b want=0", dn_tx_last); end
        @(negedge clk);
        total += 3;
        if (dn_tx_valid !== 1'b1 || dn_tx_data !== 8'hCC) begin bad++; $display("FAIL dn_slice2 got=%b/%h want=1/cc", dn_tx_valid, dn_tx_data); end
        if (dn_tx_last !== 1'b1) begin bad++; $display("FAIL dn_slice2_last got=%b want=1", dn_tx_last); end
        if (dn_rx_ready !== 1'b1) begin bad++; $display("FAIL dn_final_rx_ready got=%b want=1", dn_rx_ready); end
        @(negedge clk);
        total++;
        if (dn_tx_valid !== 1'b0) begin bad++; $display("FAIL dn_skip_dd got=%b/%h want=0", dn_tx_valid, dn_tx_data); end
        dn_rx_valid = 1'b1;
        dn_rx_data  = 32'h12345678;
        dn_rx_keep  = 4'b0000;
        dn_rx_last  = 1'b1;
        @(negedge clk);
        dn_rx_valid = 1'b0;
        total += 2;
        if (dn_tx_valid !== 1'b1 || dn_tx_last !== 1'b1) begin bad++; $display("FAIL dn_empty_last got=%b/%b want=1/1", dn_tx_valid, dn_tx_last); end
        if (dn_tx_keep !== 1'b0 || dn_tx_data !== 8'h00) begin bad++; $display("FAIL dn_empty_keepdata got=%b/%h want=0/00", dn_tx_keep, dn_tx_data); end
        @(negedge clk);
        total++;
        if (dn_tx_valid !== 1'b0) begin bad++; $display("FAIL dn_empty_once got=%b want=0", dn_tx_valid); end
        dn_rx_valid = 1'b1;
        dn_rx_last  = 1'b0;
        @(negedge clk);
        dn_rx_valid = 1'b0;
        total++;
        if (dn_tx_valid !== 1'b0) begin bad++; $display("FAIL dn_empty_drop got=%b want=0", dn_tx_valid); end
        @(negedge clk);
    endtask

    task automatic test_equal();
        eq_tx_ready = 1'b0;
        eq_rx_valid = 1'b1;
        eq_rx_data  = 16'h1234;
        eq_rx_keep  = 2'b11;
        eq_rx_last  = 1'b0;
        @(negedge clk);
        eq_rx_data = 16'h5678;
        for (int i = 0; i < 5; i++) begin
            total += 3;
            if (eq_tx_valid !== 1'b1) begin bad++; $display("FAIL eq_hold_valid cyc=%0d got=%b want=1", i, eq_tx_valid); end
            if (eq_tx_data !== 16'h1234) begin bad++; $display("FAIL eq_hold_data cyc=%0d got=%h want=1234", i, eq_tx_data); end
            if (eq_rx_ready !== 1'b0) begin bad++; $display("FAIL eq_hold_rx_ready cyc=%0d got=%b want=0", i, eq_rx_ready); end
            @(negedge clk);
        end
        eq_tx_ready = 1'b1;
        #1;
        total++;
        if (eq_rx_ready !== 1'b1) begin bad++; $display("FAIL eq_release_rx_ready got=%b want=1", eq_rx_ready); end
        @(negedge clk);
        total++;
        if (eq_tx_valid !== 1'b1 || eq_tx_data !== 16'h5678) begin bad++; $display("FAIL eq_beat2 got=%b/%h want=1/5678", eq_tx_valid, eq_tx_data); end
        eq_rx_data = 16'h9ABC;
        eq_rx_last = 1'b1;
        @(negedge clk);
        eq_rx_valid = 1'b0;
        total += 2;
        if (eq_tx_valid !== 1'b1 || eq_tx_data !== 16'h9ABC) begin bad++; $display("FAIL eq_beat3 got=%b/%h want=1/9abc", eq_tx_valid, eq_tx_data); end
        if (eq_tx_last !== 1'b1) begin bad++; $display("FAIL eq_beat3_last got=%b want=1", eq_tx_last); end
        @(negedge clk);
        total++;
        if (eq_tx_valid !== 1'b0) begin bad++; $display("FAIL eq_drained got=%b want=0", eq_tx_valid); end
    endtask

    task automatic test_reset_mid_packet();
        up_tx_ready = 1'b1;
        up_send(8'h01, 1'b0);
        up_send(8'h02, 1'b0);
        up_rx_valid = 1'b0;
        rstn = 1'b0;
        #1;
        total += 3;
        if (up_tx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", up_tx_valid); end
        if (up_tx_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h want=0", up_tx_data); end
        if (up_rx_ready !== 1'b0) begin bad++; $display("FAIL rstmid_rx_ready got=%b want=0", up_rx_ready); end
        @(negedge clk);
        rstn = 1'b1;
        up_send(8'h10, 1'b0);
        up_send(8'h20, 1'b0);
        up_send(8'h30, 1'b0);
        up_send(8'h40, 1'b1);
        up_rx_valid = 1'b0;
        total += 3;
        if (up_tx_valid !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_valid got=%b want=1", up_tx_valid); end
        if (up_tx_data !== 32'h40302010) begin bad++; $display("FAIL rstmid_fresh_data got=%h want=40302010", up_tx_data); end
        if (up_tx_keep !== 4'b1111 || up_tx_last !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_keeplast got=%b/%b want=1111/1", up_tx_keep, up_tx_last); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lim;
        lim = cyc + 40000;
        fork
            begin : up_drv
                logic [7:0] w;
                logic done;
                for (int p = 0; p < NP; p++) begin
                    for (int b = 0; b < 10; b++) begin
                        w = 8'($urandom);
                        up_q.push_back({(b == 9), w});
                        up_rx_valid = 1'b0;
                        up_rx_data  = w;
                        up_rx_last  = (b == 9);
                        up_rx_keep  = 1'b1;
                        done = 1'b0;
                        while (!done && cyc < lim) begin
                            if (!up_rx_valid && $urandom_range(99) < 30) up_rx_valid = 1'b1;
                            #4;
                            if (up_rx_valid && up_rx_ready) done = 1'b1;
                            @(negedge clk);
                        end
                    end
                end
                up_rx_valid = 1'b0;
            end
            begin : dn_drv
                logic [31:0] w;
                logic done;
                for (int p = 0; p < NP; p++) begin
                    for (int b = 0; b < 10; b++) begin
                        w = $urandom;
                        for (int k = 0; k < 4; k++) dn_q.push_back({(b == 9 && k == 3), w[k*8 +: 8]});
                        dn_rx_valid = 1'b0;
                        dn_rx_data  = w;
                        dn_rx_last  = (b == 9);
                        dn_rx_keep  = 4'hF;
                        done = 1'b0;
                        while (!done && cyc < lim) begin
                            if (!dn_rx_valid && $urandom_range(99) < 30) dn_rx_valid = 1'b1;
                            #4;
                            if (dn_rx_valid && dn_rx_ready) done = 1'b1;
                            @(negedge clk);
                        end
                    end
                end
                dn_rx_valid = 1'b0;
            end
            begin : up_mon
                int got;
                logic [8:0] e;
                logic lastf;
                got = 0;
                while (got < NP * 10 && cyc < lim) begin
                    up_tx_ready = ($urandom_range(99) < 30);
                    #4;
                    if (up_tx_valid && up_tx_ready) begin
                        lastf = 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            if (up_tx_keep[i]) begin
                                total++;
                                if (up_q.size() == 0) begin
                                    bad++;
                                    $display("FAIL bp_up_extra got=%02h want=none", up_tx_data[i*8 +: 8]);
                                end else begin
                                    e = up_q.pop_front();
                                    lastf = e[8];
                                    got++;
                                    if (up_tx_data[i*8 +: 8] !== e[7:0]) begin
                                        bad++;
                                        $display("FAIL bp_up_data word=%0d got=%02h want=%02h", got, up_tx_data[i*8 +: 8], e[7:0]);
                                    end
                                end
                            end
                        end
                        total++;
                        if (up_tx_last !== lastf) begin bad++; $display("FAIL bp_up_last word=%0d got=%b want=%b", got, up_tx_last, lastf); end
                    end
                    @(negedge clk);
                end
                total++;
                if (got != NP * 10) begin bad++; $display("FAIL bp_up_timeout got=%0d want=%0d", got, NP * 10); end
                up_tx_ready = 1'b1;
            end
            begin : dn_mon
                int got;
                logic [8:0] e;
                got = 0;
                while (got < NP * 40 && cyc < lim) begin
                    dn_tx_ready = ($urandom_range(99) < 30);
                    #4;
                    if (dn_tx_valid && dn_tx_ready) begin
                        total++;
                        if (dn_tx_keep !== 1'b1 || dn_q.size() == 0) begin
                            bad++;
                            $display("FAIL bp_dn_keep got=%b want=1 pending=%0d", dn_tx_keep, dn_q.size());
                        end else begin
                            e = dn_q.pop_front();
                            got++;
                            total++;
                            if (dn_tx_data !== e[7:0] || dn_tx_last !== e[8]) begin
                                bad++;
                                $display("FAIL bp_dn_word word=%0d got=%02h/%b want=%02h/%b", got, dn_tx_data, dn_tx_last, e[7:0], e[8]);
                            end
                        end
                    end
                    @(negedge clk);
                end
                total++;
                if (got != NP * 40) begin bad++; $display("FAIL bp_dn_timeout got=%0d want=%0d", got, NP * 40); end
                dn_tx_ready = 1'b1;
            end
        join
        total += 2;
        if (up_q.size() != 0) begin bad++; $display("FAIL bp_up_leftover got=%0d want=0", up_q.size()); end
        if (dn_q.size() != 0) begin bad++; $display("FAIL bp_dn_leftover got=%0d want=0", dn_q.size()); end
    endtask

    initial begin
        up_rx_valid = 1'b0; up_rx_data = '0; up_rx_keep = '0; up_rx_last = 1'b0; up_tx_ready = 1'b0;
        dn_rx_valid = 1'b0; dn_rx_data = '0; dn_rx_keep = '0; dn_rx_last = 1'b0; dn_tx_ready = 1'b0;
        eq_rx_valid = 1'b0; eq_rx_data = '0; eq_rx_keep = '0; eq_rx_last = 1'b0; eq_tx_ready = 1'b0;
        test_reset();
        test_upsize_full();
        test_upsize_short();
        test_downsize();
        test_equal();
        test_reset_mid_packet();
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
